ysyx_25060170_pipe_ctrl: RTL
============================

# ysyx_25060170_pipe_ctrl

Central hazard and sequencing controller for the 5-stage NPC pipeline (IF/ID/EX/LS/WB). It detects load-use hazards, branch redirects, multi-cycle EX operations, LS memory waits and traps. From these it drives the hold and flush inputs of the IF/ID, ID/EX and EX/LS pipeline registers and the PC hold. A small FSM sequences multi-cycle and memory-wait episodes, with a watchdog on memory waits and a stall-cycle performance counter.

## Interface
- MEM_TIMEOUT, 256, cycles allowed in MEM_WAIT before abort; legal range 2..65535.
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- id_valid  in  1  ID holds a valid instruction
- id_rs1_addr, id_rs2_addr  in  5 each  ID source register addresses
- id_rs1_use, id_rs2_use  in  1 each  ID instruction reads rs1/rs2
- ex_valid  in  1  EX holds a valid instruction
- ex_rd_ena  in  1  EX instruction writes rd
- ex_rd_addr  in  5  EX destination register
- ex_load_flag  in  1  EX instruction is a load
- ex_redirect  in  1  EX resolved a taken/mispredicted control transfer
- ex_mc_start  in  1  EX instruction needs the multi-cycle unit (mul/div)
- ex_mc_done  in  1  multi-cycle result valid this cycle
- ls_req  in  1  LS has an outstanding memory access
- ls_ack  in  1  memory access completes this cycle
- trap  in  1  LS raises an exception
- pc_hold, if_id_hold, id_ex_hold, ex_ls_hold  out  1 each  hold PC / the named register
- if_id_flush, id_ex_flush, ex_ls_flush  out  1 each  load a bubble into the named register
- mc_abort  out  1  one-cycle pulse: multi-cycle op cancelled
- mem_timeout  out  1  one-cycle pulse: watchdog expired
- stall_cycles  out  32  count of cycles with pc_hold=1

## Operation
- Registered state: state ∈ {RUN, MC_WAIT, MEM_WAIT}, wdog counter (16 bit), stall_cycles. All other outputs are combinational from state and inputs.
- Invariant: a register's hold and flush are never asserted in the same cycle.
- load_use = ex_valid & ex_load_flag & ex_rd_ena & (ex_rd_addr≠0) & id_valid & ((id_rs1_use & id_rs1_addr==ex_rd_addr) | (id_rs2_use & id_rs2_addr==ex_rd_addr)).
- RUN, first matching rule wins:
  1. trap: flush all three registers, no holds, stay RUN.
  2. ls_req & !ls_ack: hold PC and all three registers; wdog←0; go MEM_WAIT.
  3. ex_mc_start & !ex_mc_done: hold PC, IF/ID, ID/EX; ex_ls_flush; go MC_WAIT.
  4. ex_redirect: if_id_flush, id_ex_flush; no holds.
  5. load_use: pc_hold, if_id_hold, id_ex_flush. This lasts 1 cycle and needs no state change.
  6. Otherwise: all outputs 0.
- MEM_WAIT:
  - ls_ack: release all holds, go RUN. ex_redirect, trap and ex_mc_start are ignored during the wait. The held instructions re-present them in RUN.
  - No ack and wdog==MEM_TIMEOUT-1: mem_timeout=1, flush all three registers, no holds, go RUN.
  - Otherwise: hold all, wdog+1.
- MC_WAIT:
  - trap: flush all three registers, mc_abort=1, go RUN.
  - ex_mc_done: release holds, no flush, go RUN. The result advances to LS on the following edge.
  - Otherwise: hold PC, IF/ID, ID/EX; ex_ls_flush each cycle.
- stall_cycles increments by 1 on each clock edge where pc_hold=1, wrapping 2^32-1→0.

## Timing
- Reset (rst=1 at edge): state=RUN, wdog=0, stall_cycles=0. While rst=1, every combinational output is forced 0.
- Hazard decisions are zero-latency: outputs respond in the same cycle as their inputs.
- A load-use bubble costs exactly 1 cycle. The load is in LS on the next cycle, so no further hazard arises from it.
- ex_mc_start with ex_mc_done in the same cycle: no stall, state stays RUN.
- ls_req with ls_ack in the same cycle: no stall.
- Reset asserted in MC_WAIT or MEM_WAIT: return to RUN on that edge with no pulses.
- mc_abort and mem_timeout are each high for exactly 1 cycle.

## Test plan
- Load-use: EX=lw x5 (rd=5, load), ID uses rs1=5 -> pc_hold=if_id_hold=id_ex_flush=1 for 1 cycle; stall_cycles 0→1. Repeat with rd=0 -> no stall.
- Redirect with load_use in the same cycle -> if_id_flush=id_ex_flush=1, pc_hold=0, stall_cycles unchanged.
- Multi-cycle: ex_mc_start, ex_mc_done 4 cycles later -> 4 cycles of holds plus ex_ls_flush, then RUN; stall_cycles +4. With trap on cycle 2 -> mc_abort pulse and all flushes.
- Memory wait: ls_req, ls_ack after 3 cycles -> all four holds for 3 cycles, release on the ack cycle. A redirect during the wait is not acted on.
- Watchdog with MEM_TIMEOUT=4 and no ack -> holds for 4 cycles; mem_timeout and all flushes on the 5th cycle; state RUN.
- Counter wrap: preload via 2^32-1 stall cycles (or force) -> next stall gives stall_cycles=0. rst mid-MEM_WAIT -> all outputs 0, state RUN.

Source files
------------

// File: rtl/ysyx_25060170_pipe_ctrl.sv
// Pipeline hazard/sequencing controller: drives PC and IF/ID, ID/EX, EX/LS hold/flush.
// Zero-latency hazard decode; a small FSM covers multi-cycle EX ops and LS memory waits.
module ysyx_25060170_pipe_ctrl #(
  parameter int MEM_TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_id_valid,
  input  logic [4:0]  i_id_rs1_addr,
  input  logic [4:0]  i_id_rs2_addr,
  input  logic        i_id_rs1_use,
  input  logic        i_id_rs2_use,
  input  logic        i_ex_valid,
  input  logic        i_ex_rd_ena,
  input  logic [4:0]  i_ex_rd_addr,
  input  logic        i_ex_load_flag,
  input  logic        i_ex_redirect,
  input  logic        i_ex_mc_start,
  input  logic        i_ex_mc_done,
  input  logic        i_ls_req,
  input  logic        i_ls_ack,
  input  logic        i_trap,
  output logic        o_pc_hold,
  output logic        o_if_id_hold,
  output logic        o_id_ex_hold,
  output logic        o_ex_ls_hold,
  output logic        o_if_id_flush,
  output logic        o_id_ex_flush,
  output logic        o_ex_ls_flush,
  output logic        o_mc_abort,
  output logic        o_mem_timeout,
  output logic [31:0] o_stall_cycles
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MC_WAIT  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [15:0] WDOG_LAST = 16'(MEM_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_wdog;
  logic [15:0] w_wdog_next;
  logic [31:0] r_stall_cycles;

  logic w_load_use;
  logic w_rs1_hit;
  logic w_rs2_hit;

  logic w_pc_hold;
  logic w_if_id_hold;
  logic w_id_ex_hold;
  logic w_ex_ls_hold;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_ex_ls_flush;
  logic w_mc_abort;
  logic w_mem_timeout;

  assign w_rs1_hit  = i_id_rs1_use && (i_id_rs1_addr == i_ex_rd_addr);
  assign w_rs2_hit  = i_id_rs2_use && (i_id_rs2_addr == i_ex_rd_addr);
  assign w_load_use = i_ex_valid && i_ex_load_flag && i_ex_rd_ena &&
                      (i_ex_rd_addr != 5'd0) && i_id_valid && (w_rs1_hit || w_rs2_hit);

  always_comb begin
    w_next_state  = r_state;
    w_wdog_next   = r_wdog;
    w_pc_hold     = 1'b0;
    w_if_id_hold  = 1'b0;
    w_id_ex_hold  = 1'b0;
    w_ex_ls_hold  = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_ex_ls_flush = 1'b0;
    w_mc_abort    = 1'b0;
    w_mem_timeout = 1'b0;

    case (r_state)
      RUN: begin
        if (i_trap) begin
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
          w_ex_ls_flush = 1'b1;
        end else if (i_ls_req && !i_ls_ack) begin
          w_pc_hold    = 1'b1;
          w_if_id_hold = 1'b1;
          w_id_ex_hold = 1'b1;
          w_ex_ls_hold = 1'b1;
          w_wdog_next  = 16'd0;
          w_next_state = MEM_WAIT;
        end else if (i_ex_mc_start && !i_ex_mc_done) begin
          // EX/LS takes a bubble while the multi-cycle unit owns EX.
          w_pc_hold     = 1'b1;
          w_if_id_hold  = 1'b1;
          w_id_ex_hold  = 1'b1;
          w_ex_ls_flush = 1'b1;
          w_next_state  = MC_WAIT;
        end else if (i_ex_redirect) begin
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
        end else if (w_load_use) begin
          w_pc_hold     = 1'b1;
          w_if_id_hold  = 1'b1;
          w_id_ex_flush = 1'b1;
        end
      end

      MEM_WAIT: begin
        // Redirects, traps and mc starts here come from held instructions and
        // are re-presented once the pipeline resumes.
        if (i_ls_ack) begin
          w_next_state = RUN;
        end else if (r_wdog == WDOG_LAST) begin
          w_mem_timeout = 1'b1;
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
          w_ex_ls_flush = 1'b1;
          w_next_state  = RUN;
        end else begin
          w_pc_hold    = 1'b1;
          w_if_id_hold = 1'b1;
          w_id_ex_hold = 1'b1;
          w_ex_ls_hold = 1'b1;
          w_wdog_next  = r_wdog + 16'd1;
        end
      end

      MC_WAIT: begin
        if (i_trap) begin
          w_mc_abort    = 1'b1;
          w_if_id_flush = 1'b1;
          w_id_ex_flush = 1'b1;
          w_ex_ls_flush = 1'b1;
          w_next_state  = RUN;
        end else if (i_ex_mc_done) begin
          w_next_state = RUN;
        end else begin
          w_pc_hold     = 1'b1;
          w_if_id_hold  = 1'b1;
          w_id_ex_hold  = 1'b1;
          w_ex_ls_flush = 1'b1;
        end
      end

      default: begin
        w_next_state = RUN;
      end
    endcase

    if (rst) begin
      w_pc_hold     = 1'b0;
      w_if_id_hold  = 1'b0;
      w_id_ex_hold  = 1'b0;
      w_ex_ls_hold  = 1'b0;
      w_if_id_flush = 1'b0;
      w_id_ex_flush = 1'b0;
      w_ex_ls_flush = 1'b0;
      w_mc_abort    = 1'b0;
      w_mem_timeout = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= RUN;
      r_wdog         <= 16'd0;
      r_stall_cycles <= 32'd0;
    end else begin
      r_state <= w_next_state;
      r_wdog  <= w_wdog_next;
      if (w_pc_hold) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
    end
  end

  assign o_pc_hold      = w_pc_hold;
  assign o_if_id_hold   = w_if_id_hold;
  assign o_id_ex_hold   = w_id_ex_hold;
  assign o_ex_ls_hold   = w_ex_ls_hold;
  assign o_if_id_flush  = w_if_id_flush;
  assign o_id_ex_flush  = w_id_ex_flush;
  assign o_ex_ls_flush  = w_ex_ls_flush;
  assign o_mc_abort     = w_mc_abort;
  assign o_mem_timeout  = w_mem_timeout;
  assign o_stall_cycles = r_stall_cycles;

endmodule
